// File: rtl/multi_timer.sv
// Multi-channel period timer: a shared free-running prescaler feeds NUM_CH
// independent one-shot/auto-reload counters with done pulses and finish flags.
module multi_timer #(
  parameter int SIZE   = 16,
  parameter int NUM_CH = 4,
  parameter int PRE_W  = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [PRE_W-1:0]         prescale,
  input  logic [NUM_CH*SIZE-1:0]   period,
  input  logic [NUM_CH-1:0]        start,
  input  logic [NUM_CH-1:0]        stop,
  input  logic [NUM_CH-1:0]        auto_reload,
  output logic [NUM_CH-1:0]        running,
  output logic [NUM_CH-1:0]        count_finish,
  output logic [NUM_CH-1:0]        done,
  output logic [NUM_CH*SIZE-1:0]   count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  logic [PRE_W-1:0] pre_cnt_q;
  logic             tick_s;

  // The >= compare lets a lowered prescale take effect without waiting for a wrap.
  assign tick_s = (pre_cnt_q >= prescale);

  // Shared prescaler: free-running, never cleared by channel control.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre_cnt_q <= '0;
    end else if (tick_s) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_q + PRE_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e          state_q;
    logic [SIZE-1:0] count_q;
    logic [SIZE-1:0] period_q;
    logic [SIZE-1:0] period_in_s;
    logic [SIZE-1:0] count_inc_s;
    logic            done_q;
    logic            run_q;
    logic            fin_q;

    assign period_in_s = period[i*SIZE +: SIZE];
    assign count_inc_s = count_q + SIZE'(1);

    // Channel FSM; stop has priority over start, start over counting.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        state_q  <= ST_IDLE;
        count_q  <= '0;
        period_q <= '0;
        done_q   <= 1'b0;
        run_q    <= 1'b0;
        fin_q    <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (stop[i]) begin
          state_q <= ST_IDLE;
          run_q   <= 1'b0;
          fin_q   <= 1'b0;
        end else if (start[i]) begin
          period_q <= period_in_s;
          count_q  <= '0;
          if (period_in_s != '0) begin
            state_q <= ST_RUN;
            run_q   <= 1'b1;
            fin_q   <= 1'b0;
          end else begin
            state_q <= ST_FINISH;
            run_q   <= 1'b0;
            fin_q   <= 1'b1;
            done_q  <= 1'b1;
          end
        end else begin
          case (state_q)
            ST_RUN: begin
              if (tick_s) begin
                if (count_inc_s == period_q) begin
                  done_q <= 1'b1;
                  if (auto_reload[i]) begin
                    count_q  <= '0;
                    period_q <= period_in_s;
                    // A reloaded period of zero behaves as a stop into FINISH.
                    if (period_in_s == '0) begin
                      state_q <= ST_FINISH;
                      run_q   <= 1'b0;
                      fin_q   <= 1'b1;
                    end else begin
                      state_q <= ST_RUN;
                    end
                  end else begin
                    count_q <= period_q;
                    state_q <= ST_FINISH;
                    run_q   <= 1'b0;
                    fin_q   <= 1'b1;
                  end
                end else begin
                  count_q <= count_inc_s;
                end
              end else begin
                count_q <= count_q;
              end
            end
            ST_FINISH: state_q <= ST_FINISH;
            ST_IDLE:   state_q <= ST_IDLE;
            default: begin
              state_q <= ST_IDLE;
              run_q   <= 1'b0;
              fin_q   <= 1'b0;
            end
          endcase
        end
      end
    end

    assign running[i]              = run_q;
    assign count_finish[i]         = fin_q;
    assign done[i]                 = done_q;
    assign count[i*SIZE +: SIZE]   = count_q;
  end

endmodule

// File: tb/tb_multi_timer.sv
// Directed plus randomized checks of multi_timer against a behavioural model.
module tb_multi_timer;
  localparam int SIZE   = 16;
  localparam int NUM_CH = 4;
  localparam int PRE_W  = 8;

  logic                   CLK = 1'b0;
  logic                   RST;
  logic [PRE_W-1:0]       prescale;
  logic [NUM_CH*SIZE-1:0] period;
  logic [NUM_CH-1:0]      start, stop, auto_reload;
  logic [NUM_CH-1:0]      running, count_finish, done;
  logic [NUM_CH*SIZE-1:0] count;

  int checks = 0;
  int errors = 0;

  // reference model: 0 idle, 1 run, 2 finish
  int m_pre;
  int m_st  [NUM_CH];
  int m_cnt [NUM_CH];
  int m_per [NUM_CH];
  bit m_done[NUM_CH];

  always #5 CLK = ~CLK;

  multi_timer #(.SIZE(SIZE), .NUM_CH(NUM_CH), .PRE_W(PRE_W)) dut (
    .CLK(CLK), .RST(RST), .prescale(prescale), .period(period),
    .start(start), .stop(stop), .auto_reload(auto_reload),
    .running(running), .count_finish(count_finish), .done(done), .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int per_of(input int ch);
    logic [SIZE-1:0] p;
    p = period[ch*SIZE +: SIZE];
    return int'(p);
  endfunction

  task automatic model_reset();
    m_pre = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_st[c] = 0; m_cnt[c] = 0; m_per[c] = 0; m_done[c] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit tk;
    tk = (m_pre >= int'(prescale));
    m_pre = tk ? 0 : m_pre + 1;
    for (int c = 0; c < NUM_CH; c++) begin
      m_done[c] = 1'b0;
      if (stop[c]) begin
        m_st[c] = 0;
      end else if (start[c]) begin
        m_per[c] = per_of(c);
        m_cnt[c] = 0;
        if (m_per[c] == 0) begin m_st[c] = 2; m_done[c] = 1'b1; end
        else m_st[c] = 1;
      end else if (m_st[c] == 1 && tk) begin
        if (m_cnt[c] + 1 == m_per[c]) begin
          m_done[c] = 1'b1;
          if (auto_reload[c]) begin
            m_cnt[c] = 0;
            m_per[c] = per_of(c);
            if (m_per[c] == 0) m_st[c] = 2;
          end else begin
            m_cnt[c] = m_per[c];
            m_st[c]  = 2;
          end
        end else begin
          m_cnt[c] = m_cnt[c] + 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [NUM_CH-1:0]      er, ef, ed;
    logic [NUM_CH*SIZE-1:0] ec;
    for (int c = 0; c < NUM_CH; c++) begin
      er[c] = (m_st[c] == 1);
      ef[c] = (m_st[c] == 2);
      ed[c] = m_done[c];
      ec[c*SIZE +: SIZE] = SIZE'(m_cnt[c]);
    end
    chk({tag, ".running"}, 64'(running), 64'(er));
    chk({tag, ".finish"},  64'(count_finish), 64'(ef));
    chk({tag, ".done"},    64'(done), 64'(ed));
    chk({tag, ".count"},   64'(count), 64'(ec));
  endtask

  task automatic step(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check_all(tag);
    start = '0;
    stop  = '0;
  endtask

  task automatic set_per(input int ch, input int p);
    period[ch*SIZE +: SIZE] = SIZE'(p);
  endtask

  initial begin
    int npulses, last, first_gap;
    RST = 1'b1; prescale = '0; period = '0; start = '0; stop = '0; auto_reload = '0;
    #12;
    chk("rst.running", 64'(running), 64'd0);
    chk("rst.count",   64'(count), 64'd0);
    chk("rst.done",    64'(done | count_finish), 64'd0);
    model_reset();
    RST = 1'b0;

    // reset mid-run
    set_per(0, 100); start[0] = 1'b1;
    step("mr_start");
    for (int k = 0; k < 40; k++) step("mr_run");
    chk("mr.count40", 64'(count[15:0]), 64'd40);
    RST = 1'b1;
    #1;
    chk("mr.async_run",   64'(running), 64'd0);
    chk("mr.async_count", 64'(count), 64'd0);
    chk("mr.async_flags", 64'(done | count_finish), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    step("mr_after");
    chk("mr.idle", 64'(running[0]), 64'd0);

    // one-shot, period 5
    set_per(0, 5); auto_reload = '0; start[0] = 1'b1;
    step("os_start");
    for (int k = 1; k <= 5; k++) begin
      step("os_run");
      chk("os.count", 64'(count[15:0]), 64'(k));
      chk("os.done",  64'(done[0]), 64'(k == 5));
    end
    for (int k = 0; k < 20; k++) begin
      step("os_hold");
      chk("os.hold_fin", 64'(count_finish[0]), 64'd1);
      chk("os.hold_cnt", 64'(count[15:0]), 64'd5);
    end

    // auto-reload with prescale 3
    prescale = 8'd3; set_per(1, 4); auto_reload[1] = 1'b1; start[1] = 1'b1;
    step("ar_start");
    npulses = 0; last = -1; first_gap = 0;
    for (int k = 1; k <= 48; k++) begin
      step("ar_run");
      chk("ar.running", 64'(running[1]), 64'd1);
      if (done[1]) begin
        if (last >= 0) chk("ar.interval", 64'(k - last), 64'd16);
        last = k; npulses++;
      end
    end
    chk("ar.pulses", 64'(npulses), 64'd3);
    stop = 4'b0011;
    step("ar_stop");

    // zero period
    prescale = 8'd0; set_per(2, 0); start[2] = 1'b1;
    step("zp_start");
    chk("zp.fin",  64'(count_finish[2]), 64'd1);
    chk("zp.done", 64'(done[2]), 64'd1);
    chk("zp.cnt",  64'(count[47:32]), 64'd0);
    step("zp_after");
    chk("zp.done_once", 64'(done[2]), 64'd0);

    // start+stop together in RUN
    set_per(0, 10); start[0] = 1'b1;
    step("ss_start");
    for (int k = 0; k < 5; k++) step("ss_run");
    start[0] = 1'b1; stop[0] = 1'b1;
    step("ss_both");
    chk("ss.running", 64'(running[0]), 64'd0);
    chk("ss.count",   64'(count[15:0]), 64'd5);

    // restart in RUN at count 7
    start[0] = 1'b1;
    step("rs_start");
    for (int k = 0; k < 7; k++) step("rs_run");
    chk("rs.count7", 64'(count[15:0]), 64'd7);
    start[0] = 1'b1;
    step("rs_restart");
    chk("rs.count0", 64'(count[15:0]), 64'd0);
    for (int k = 1; k <= 10; k++) begin
      step("rs_run2");
      chk("rs.done", 64'(done[0]), 64'(k == 10));
    end

    // stop at count 3
    start[0] = 1'b1;
    step("sp_start");
    for (int k = 0; k < 3; k++) step("sp_run");
    stop[0] = 1'b1;
    step("sp_stop");
    chk("sp.count", 64'(count[15:0]), 64'd3);
    for (int k = 0; k < 12; k++) step("sp_idle");

    // channel independence
    stop = '1;
    step("ci_clear");
    set_per(0, 3); set_per(1, 5); set_per(2, 7); set_per(3, 3);
    auto_reload = '1; start = '1;
    step("ci_start");
    for (int k = 1; k <= 3; k++) step("ci_run");
    chk("ci.done03", 64'(done), 64'b1001);
    stop[2] = 1'b1;
    step("ci_stop2");
    start[1] = 1'b1;
    step("ci_restart1");
    for (int k = 0; k < 25; k++) step("ci_run2");

    // full-range period
    stop = '1;
    step("fr_clear");
    auto_reload = '0; set_per(3, 65535); start[3] = 1'b1;
    step("fr_start");
    for (int k = 1; k <= 65535; k++) step("fr_run");
    chk("fr.done",  64'(done[3]), 64'd1);
    chk("fr.count", 64'(count[63:48]), 64'hFFFF);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(15, 0) == 0) prescale = PRE_W'($urandom_range(3, 0));
      for (int c = 0; c < NUM_CH; c++) begin
        set_per(c, int'($urandom_range(9, 0)));
        start[c] = ($urandom_range(7, 0) == 0);
        stop[c]  = ($urandom_range(15, 0) == 0);
        if ($urandom_range(7, 0) == 0) auto_reload[c] = 1'($urandom_range(1, 0));
      end
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
